rr_matrix_arbiter: RTL and testbench

RR_MATRIX_ARBITER -- requirements
Module: rr_matrix_arbiter

---
 rtl/rr_matrix_arbiter_if.sv | 29 ++
 rtl/rr_matrix_arbiter.sv | 78 +++++++
 tb/tb_rr_matrix_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rr_matrix_arbiter_if.sv
// rtl/rr_matrix_arbiter_if.sv - request/grant bundle for the round-robin matrix arbiter
//
// Purpose: groups the arbiter's request and grant vectors so requesters and
// the arbiter connect through a single port.
//
// Signals:
//   request_vector [N-1:0]  bit i high = requester i requests this cycle
//   grant_vector   [N-1:0]  bit i high = requester i granted this cycle
//
// Modports:
//   master - the requesting side (drives request_vector, reads grant_vector)
//   slave  - the arbiter (reads request_vector, drives grant_vector)

interface rr_matrix_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0] request_vector;
  logic [N-1:0] grant_vector;

  modport master (
    output request_vector,
    input  grant_vector
  );

  modport slave (
    input  request_vector,
    output grant_vector
  );
endinterface

// File: rtl/rr_matrix_arbiter.sv
// rtl/rr_matrix_arbiter.sv - same-cycle round-robin arbiter built on a priority matrix
//
// Purpose: grants at most one of N requesters per cycle. Priority is held as
// a triangular matrix of state bits; the granted requester drops to lowest
// priority at the clock edge, the relative order of all others is kept.
//
// Parameters:
//   P_ROUTER_ID   router identifier, informational only
//   P_CHANNEL_ID  channel identifier, informational only
//   N             number of requesters, 2..16
//
// Ports:
//   CLK  input   single clock, all state changes on the rising edge
//   RST  input   synchronous active-high reset; forces grants to zero and
//                restores lowest-index-first priority
//   arb  slave   request_vector in, grant_vector out (combinational grant)

module rr_matrix_arbiter #(
  parameter int P_ROUTER_ID  = 0,
  parameter int P_CHANNEL_ID = 0,
  parameter int N            = 2
) (
  input  logic              CLK,
  input  logic              RST,
  rr_matrix_arbiter_if.slave arb
);

  // One state bit per unordered pair (i<j); bit set means i beats j.
  localparam int LP_NB = (N * (N - 1)) / 2;

  if (N < 2 || N > 16 || P_ROUTER_ID < 0 || P_CHANNEL_ID < 0) begin : g_param_check
    $error("rr_matrix_arbiter: N must be 2..16 and identifiers non-negative");
  end

  logic [LP_NB-1:0]        r_tri;
  logic [LP_NB-1:0]        w_tri_next;
  logic [N-1:0]            w_req;
  logic [N-1:0]            w_grant_raw;
  logic [N-1:0]            w_grant;
  // w_beats[i][j]: i is not blocked by j. The diagonal is tied high so a
  // requester never blocks itself in the AND-reduction below.
  logic [N-1:0][N-1:0]     w_beats;

  assign w_req = arb.request_vector;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gi < gj) begin : g_upper
        localparam int LP_IDX = gi * N - (gi * (gi + 1)) / 2 + (gj - gi - 1);
        assign w_beats[gi][gj] = r_tri[LP_IDX];
        // Granted i falls below j; granted j falls below i; otherwise hold.
        assign w_tri_next[LP_IDX] = w_grant[gi] ? 1'b0 :
                                    (w_grant[gj] ? 1'b1 : r_tri[LP_IDX]);
      end else if (gi > gj) begin : g_lower
        localparam int LP_IDX = gj * N - (gj * (gj + 1)) / 2 + (gi - gj - 1);
        assign w_beats[gi][gj] = ~r_tri[LP_IDX];
      end else begin : g_diag
        assign w_beats[gi][gj] = 1'b1;
      end
    end

    // Requester wins when every other active requester ranks below it.
    assign w_grant_raw[gi] = w_req[gi] & (&(~w_req | w_beats[gi]));
  end

  // Reset masks grants, which also keeps the matrix update idle.
  assign w_grant          = RST ? '0 : w_grant_raw;
  assign arb.grant_vector = w_grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tri <= {LP_NB{1'b1}};
    end else begin
      r_tri <= w_tri_next;
    end
  end

endmodule

// File: tb/tb_rr_matrix_arbiter.sv
// tb/tb_rr_matrix_arbiter.sv - self-checking bench for rr_matrix_arbiter (N=2 and N=4)

module tb_rr_matrix_arbiter;

  typedef int ord_t [4];

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rr_matrix_arbiter_if #(.N(2)) if2 ();
  rr_matrix_arbiter_if #(.N(4)) if4 ();

  rr_matrix_arbiter #(.P_ROUTER_ID(0), .P_CHANNEL_ID(0), .N(2)) dut2 (
    .CLK(clk),
    .RST(rst),
    .arb(if2)
  );

  rr_matrix_arbiter #(.P_ROUTER_ID(3), .P_CHANNEL_ID(1), .N(4)) dut4 (
    .CLK(clk),
    .RST(rst),
    .arb(if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an ordered list of requester indices, highest priority first.
  function automatic logic [3:0] m_grant(input ord_t o, input int n, input logic [3:0] req);
    logic [3:0] g = '0;
    bit found = 0;
    for (int k = 0; k < n; k++) begin
      if (!found && req[o[k]]) begin
        g[o[k]] = 1'b1;
        found = 1;
      end
    end
    return g;
  endfunction

  function automatic ord_t m_next(input ord_t o, input int n, input logic [3:0] g);
    ord_t r = o;
    int w = 0;
    int gi = -1;
    for (int k = 0; k < n; k++) if (g[o[k]]) gi = o[k];
    if (gi < 0) return o;
    for (int k = 0; k < n; k++) begin
      if (o[k] != gi) begin
        r[w] = o[k];
        w++;
      end
    end
    r[n-1] = gi;
    return r;
  endfunction

  function automatic ord_t m_reset();
    ord_t r;
    for (int k = 0; k < 4; k++) r[k] = k;
    return r;
  endfunction

  ord_t ord2;
  ord_t ord4;
  bit   model_valid = 0;

  // Per-cycle compare against the model, then advance the model by what the
  // coming rising edge will do with the (stable) inputs.
  always @(negedge clk) begin
    logic [3:0] e2;
    logic [3:0] e4;
    logic [3:0] r2;
    r2 = {2'b00, if2.request_vector};
    if (rst || model_valid) begin
      e2 = rst ? 4'b0000 : m_grant(ord2, 2, r2);
      e4 = rst ? 4'b0000 : m_grant(ord4, 4, if4.request_vector);
      tests++;
      if (if2.grant_vector !== e2[1:0]) begin
        fails++;
        $display("FAIL model_n2 t=%0t req=%b got=%b exp=%b", $time, if2.request_vector, if2.grant_vector, e2[1:0]);
      end
      tests++;
      if (if4.grant_vector !== e4) begin
        fails++;
        $display("FAIL model_n4 t=%0t req=%b got=%b exp=%b", $time, if4.request_vector, if4.grant_vector, e4);
      end
      tests++;
      assert ($onehot0(if4.grant_vector) && ((if4.grant_vector & ~if4.request_vector) == 4'b0000) &&
              $onehot0(if2.grant_vector) && ((if2.grant_vector & ~if2.request_vector) == 2'b00))
      else begin
        fails++;
        $display("FAIL onehot_subset t=%0t got2=%b req2=%b got4=%b req4=%b", $time,
                 if2.grant_vector, if2.request_vector, if4.grant_vector, if4.request_vector);
      end
      if (rst) begin
        ord2 = m_reset();
        ord4 = m_reset();
        model_valid = 1;
      end else begin
        ord2 = m_next(ord2, 2, e2);
        ord4 = m_next(ord4, 4, e4);
      end
    end
  end

  // One directed cycle with hand-computed grants for both instances.
  task automatic step(input logic r, input logic [1:0] q2, input logic [1:0] x2,
                      input logic [3:0] q4, input logic [3:0] x4);
    @(posedge clk);
    #1;
    rst = r;
    if2.request_vector = q2;
    if4.request_vector = q4;
    @(negedge clk);
    #1;
    tests++;
    if (if2.grant_vector !== x2) begin
      fails++;
      $display("FAIL vec_n2 t=%0t req=%b got=%b exp=%b", $time, q2, if2.grant_vector, x2);
    end
    tests++;
    if (if4.grant_vector !== x4) begin
      fails++;
      $display("FAIL vec_n4 t=%0t req=%b got=%b exp=%b", $time, q4, if4.grant_vector, x4);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    if2.request_vector = 2'b11;
    if4.request_vector = 4'b1111;

    // Reset state: grants forced low while RST is high.
    step(1, 2'b11, 2'b00, 4'b1111, 4'b0000);
    step(1, 2'b11, 2'b00, 4'b1111, 4'b0000);

    // Continuous requests rotate through everyone.
    step(0, 2'b11, 2'b01, 4'b1111, 4'b0001);
    step(0, 2'b11, 2'b10, 4'b1111, 4'b0010);
    step(0, 2'b11, 2'b01, 4'b1111, 4'b0100);
    step(0, 2'b00, 2'b00, 4'b1111, 4'b1000);
    step(0, 2'b00, 2'b00, 4'b1111, 4'b0001);

    // Single grant moves that requester to the back.
    step(1, 2'b11, 2'b00, 4'b1111, 4'b0000);
    step(0, 2'b10, 2'b10, 4'b1010, 4'b0010);
    step(0, 2'b11, 2'b01, 4'b1010, 4'b1000);
    step(0, 2'b00, 2'b00, 4'b1111, 4'b0001);

    // Idle cycles leave the order untouched.
    step(1, 2'b11, 2'b00, 4'b1111, 4'b0000);
    step(0, 2'b00, 2'b00, 4'b0000, 4'b0000);
    step(0, 2'b00, 2'b00, 4'b0000, 4'b0000);
    step(0, 2'b00, 2'b00, 4'b0000, 4'b0000);
    step(0, 2'b11, 2'b01, 4'b0100, 4'b0100);
    step(0, 2'b11, 2'b10, 4'b1111, 4'b0001);

    // Mid-operation reset discards the rotated order.
    step(0, 2'b01, 2'b01, 4'b0001, 4'b0001);
    step(1, 2'b11, 2'b00, 4'b1111, 4'b0000);
    step(0, 2'b11, 2'b01, 4'b1111, 4'b0001);

    // Random traffic with occasional resets, checked by the model only.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 39) == 0);
      if2.request_vector = 2'($urandom_range(0, 3));
      if4.request_vector = 4'($urandom_range(0, 15));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    if2.request_vector = 2'b00;
    if4.request_vector = 4'b0000;
    @(negedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
